// File: rtl/hub75_scan_driver_if.sv
// Pixel-read bus between the HUB75 scan driver (reader) and a frame source.
// The source must return ram_data exactly one cycle after ram_address.
interface hub75_scan_driver_if;
  logic [8:0]  ram_address;  // {row[3:0], col[4:0]}
  logic [47:0] ram_data;     // [47:24] lower-half pixel, [23:0] upper-half pixel

  modport master (output ram_address, input ram_data);
  modport slave  (input ram_address, output ram_data);
endinterface

// File: rtl/hub75_scan_driver.sv
// HUB75 1/16-scan driver for one 32x32 panel: shifts each row pair once per
// bit plane, then latches and shows it with binary-code-modulated on-times.
module hub75_scan_driver #(
  parameter int CLK_DIV = 2,
  parameter int BASE_ON = 8,
  parameter int PLANES  = 8,
  parameter int BLANK   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  hub75_scan_driver_if.master        ram,
  output logic                       r1,
  output logic                       g1,
  output logic                       b1,
  output logic                       r2,
  output logic                       g2,
  output logic                       b2,
  output logic                       panel_clk,
  output logic                       lat,
  output logic                       oe_n,
  output logic [3:0]                 row_addr,
  output logic                       frame_done
);

  localparam logic [2:0] S_SHIFT_ADDR = 3'd0;
  localparam logic [2:0] S_SHIFT_WAIT = 3'd1;
  localparam logic [2:0] S_SHIFT_LO   = 3'd2;
  localparam logic [2:0] S_SHIFT_HI   = 3'd3;
  localparam logic [2:0] S_BLANK      = 3'd4;
  localparam logic [2:0] S_LATCH      = 3'd5;
  localparam logic [2:0] S_SHOW       = 3'd6;

  localparam int SHOW_MAX = BASE_ON << (PLANES - 1);
  localparam int CNT_W    = ($clog2(SHOW_MAX + 1) > 16) ? $clog2(SHOW_MAX + 1) : 16;

  logic [2:0]       state;
  logic [3:0]       row;
  logic [2:0]       plane;
  logic [4:0]       col;
  logic [CNT_W-1:0] cnt;

  logic [2:0]       bit_sel;
  logic [CNT_W-1:0] show_last;
  logic             div_done;
  logic             blank_done;
  logic             show_done;
  logic             last_plane;
  logic [7:0]       top_r, top_g, top_b, bot_r, bot_g, bot_b;

  // Fewer planes means only the MSBs of each channel are displayed.
  assign bit_sel    = 3'(8 - PLANES) + plane;
  assign show_last  = (CNT_W'(BASE_ON) << plane) - CNT_W'(1);
  assign div_done   = (cnt == CNT_W'(CLK_DIV - 1));
  assign blank_done = (cnt == CNT_W'(BLANK - 1));
  assign show_done  = (cnt == show_last);
  assign last_plane = (plane == 3'(PLANES - 1));

  assign top_r = ram.ram_data[23:16];
  assign top_g = ram.ram_data[15:8];
  assign top_b = ram.ram_data[7:0];
  assign bot_r = ram.ram_data[47:40];
  assign bot_g = ram.ram_data[39:32];
  assign bot_b = ram.ram_data[31:24];

  // NOTE: every output is a register loaded on the edge entering its state, so
  // the panel pins never glitch; all state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_SHIFT_ADDR;
      row             <= '0;
      plane           <= '0;
      col             <= '0;
      cnt             <= '0;
      ram.ram_address <= '0;
      {r1, g1, b1, r2, g2, b2} <= '0;
      panel_clk       <= 1'b0;
      lat             <= 1'b0;
      oe_n            <= 1'b1;
      row_addr        <= '0;
      frame_done      <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_SHIFT_ADDR: state <= S_SHIFT_WAIT;

        S_SHIFT_WAIT: begin
          // Colour bits change only here, giving CLK_DIV cycles of setup.
          r1    <= top_r[bit_sel];
          g1    <= top_g[bit_sel];
          b1    <= top_b[bit_sel];
          r2    <= bot_r[bit_sel];
          g2    <= bot_g[bit_sel];
          b2    <= bot_b[bit_sel];
          cnt   <= '0;
          state <= S_SHIFT_LO;
        end

        S_SHIFT_LO: begin
          if (div_done) begin
            cnt       <= '0;
            panel_clk <= 1'b1;
            state     <= S_SHIFT_HI;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_SHIFT_HI: begin
          if (div_done) begin
            cnt       <= '0;
            panel_clk <= 1'b0;
            if (col == 5'd31) begin
              row_addr <= row;
              state    <= S_BLANK;
            end else begin
              col             <= col + 5'd1;
              ram.ram_address <= {row, col + 5'd1};
              state           <= S_SHIFT_ADDR;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_BLANK: begin
          if (blank_done) begin
            cnt   <= '0;
            lat   <= 1'b1;
            state <= S_LATCH;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_LATCH: begin
          lat   <= 1'b0;
          oe_n  <= 1'b0;
          state <= S_SHOW;
        end

        S_SHOW: begin
          if (show_done) begin
            cnt   <= '0;
            oe_n  <= 1'b1;
            col   <= '0;
            state <= S_SHIFT_ADDR;
            if (last_plane) begin
              plane           <= '0;
              row             <= row + 4'd1;
              ram.ram_address <= {row + 4'd1, 5'd0};
              frame_done      <= (row == 4'd15);
            end else begin
              plane           <= plane + 3'd1;
              ram.ram_address <= {row, 5'd0};
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: state <= S_SHIFT_ADDR;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Scoreboard bench: expected shift/show events are queued from the pixel
// memories; negedge monitors pop and compare as the panels are driven.
module tb_hub75_scan_driver;

  localparam int CD_A = 2, BO_A = 8, PL_A = 8, BL_A = 2;
  localparam int CD_B = 1, BO_B = 8, PL_B = 4, BL_B = 2;
  localparam int COL_A   = 2 + 2 * CD_A;
  localparam int FRAME_A = 16 * (PL_A * (32 * (2 + 2 * CD_A) + BL_A + 1) + BO_A * ((1 << PL_A) - 1));
  localparam int FRAME_B = 16 * (PL_B * (32 * (2 + 2 * CD_B) + BL_B + 1) + BO_B * ((1 << PL_B) - 1));
  localparam int RESET_LAT = 2 * 0 + 128 + 5 * PL_A + 3 + 1;  // latches seen once row 5 plane 3 of frame 2 latches

  typedef struct packed { logic [8:0] addr; logic [5:0] rgb; } shift_t;
  typedef struct packed { logic [3:0] row; logic [15:0] len; } show_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic r1_a, g1_a, b1_a, r2_a, g2_a, b2_a, pclk_a, lat_a, oe_n_a, fd_a;
  logic r1_b, g1_b, b1_b, r2_b, g2_b, b2_b, pclk_b, lat_b, oe_n_b, fd_b;
  logic [3:0] row_addr_a, row_addr_b;

  hub75_scan_driver_if bus_a ();
  hub75_scan_driver_if bus_b ();

  hub75_scan_driver #(.CLK_DIV(CD_A), .BASE_ON(BO_A), .PLANES(PL_A), .BLANK(BL_A)) dut_a (
    .clk(clk), .rst(rst_a), .ram(bus_a),
    .r1(r1_a), .g1(g1_a), .b1(b1_a), .r2(r2_a), .g2(g2_a), .b2(b2_a),
    .panel_clk(pclk_a), .lat(lat_a), .oe_n(oe_n_a), .row_addr(row_addr_a), .frame_done(fd_a));

  hub75_scan_driver #(.CLK_DIV(CD_B), .BASE_ON(BO_B), .PLANES(PL_B), .BLANK(BL_B)) dut_b (
    .clk(clk), .rst(rst_b), .ram(bus_b),
    .r1(r1_b), .g1(g1_b), .b1(b1_b), .r2(r2_b), .g2(g2_b), .b2(b2_b),
    .panel_clk(pclk_b), .lat(lat_b), .oe_n(oe_n_b), .row_addr(row_addr_b), .frame_done(fd_b));

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, rel_cyc = 0;
  logic [47:0] mem_a [512];
  logic [47:0] mem_b [512];
  shift_t q_shift_a[$], q_shift_b[$];
  show_t  q_show_a[$];
  int lat_cnt_a = 0, fd_cnt_a = 0, fd_cnt_b = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered frame sources: one cycle of read latency.
  always @(posedge clk) bus_a.ram_data <= mem_a[bus_a.ram_address];
  always @(posedge clk) bus_b.ram_data <= mem_b[bus_b.ram_address];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Pixel word -> {r1,g1,b1,r2,g2,b2} for the given plane.
  function automatic logic [5:0] exp_rgb(input logic [47:0] w, input int planes, input int p);
    logic [7:0] ch [6];
    int b;
    b = 8 - planes + p;
    ch[0] = w[23:16]; ch[1] = w[15:8];  ch[2] = w[7:0];
    ch[3] = w[47:40]; ch[4] = w[39:32]; ch[5] = w[31:24];
    exp_rgb = '0;
    for (int k = 0; k < 6; k++) exp_rgb[5 - k] = (ch[k] >> b) & 8'd1;
  endfunction

  task automatic push_frame_a();
    shift_t e;
    show_t s;
    for (int r = 0; r < 16; r++)
      for (int p = 0; p < PL_A; p++) begin
        for (int c = 0; c < 32; c++) begin
          e.addr = 9'(r * 32 + c);
          e.rgb  = exp_rgb(mem_a[r * 32 + c], PL_A, p);
          q_shift_a.push_back(e);
        end
        s.row = 4'(r);
        s.len = 16'(BO_A << p);
        q_show_a.push_back(s);
      end
  endtask

  task automatic push_frame_b();
    shift_t e;
    for (int r = 0; r < 16; r++)
      for (int p = 0; p < PL_B; p++)
        for (int c = 0; c < 32; c++) begin
          e.addr = 9'(r * 32 + c);
          e.rgb  = exp_rgb(mem_b[r * 32 + c], PL_B, p);
          q_shift_b.push_back(e);
        end
  endtask

  // Monitor for the default-parameter panel.
  logic a_started = 1'b0, a_off = 1'b0, a_first = 1'b1;
  logic a_in_show = 1'b0, a_saw_lat = 1'b0, a_prev_pclk = 1'b0;
  logic [8:0] a_last_addr = '0;
  logic [3:0] a_show_row = '0;
  int a_hold = 0, a_rises = 0, a_show_cnt = 0, a_fd_ref = 0;

  always @(negedge clk) begin
    shift_t e;
    show_t s;
    if (rst_a) begin
      if (a_started) a_off = 1'b1;
      a_hold = 0; a_rises = 0; a_in_show = 1'b0; a_saw_lat = 1'b0;
      a_prev_pclk = 1'b0; a_last_addr = '0; a_first = 1'b1;
    end else if (!a_off) begin
      a_started = 1'b1;
      if (bus_a.ram_address != a_last_addr) begin
        if (a_last_addr[4:0] != 5'd31) check("addr_hold_a", a_hold, COL_A);
        a_last_addr = bus_a.ram_address;
        a_hold = 1;
      end else begin
        a_hold++;
      end
      if (pclk_a && !a_prev_pclk) begin
        if (a_first) begin
          check("first_rise_a", cyc - rel_cyc, 2 + CD_A);
          a_first = 1'b0;
        end
        a_rises++;
        check("shift_while_dark_a", {lat_a, oe_n_a}, 2'b01);
        check("shift_queue_a", q_shift_a.size() > 0, 1);
        if (q_shift_a.size() > 0) begin
          e = q_shift_a.pop_front();
          check("addr_a", bus_a.ram_address, e.addr);
          check("rgb_a", {r1_a, g1_a, b1_a, r2_a, g2_a, b2_a}, e.rgb);
        end
      end
      a_prev_pclk = pclk_a;
      if (a_in_show) begin
        if (!oe_n_a) a_show_cnt++;
        else begin
          check("show_queue_a", q_show_a.size() > 0, 1);
          if (q_show_a.size() > 0) begin
            s = q_show_a.pop_front();
            check("show_len_a", a_show_cnt, s.len);
            check("show_row_a", a_show_row, s.row);
          end
          a_in_show = 1'b0;
        end
      end
      if (a_saw_lat) begin
        check("lat_then_show_a", {lat_a, oe_n_a}, 2'b00);
        a_in_show = 1'b1; a_show_cnt = 1; a_show_row = row_addr_a; a_saw_lat = 1'b0;
      end
      if (lat_a) begin
        check("rises_per_latch_a", a_rises, 32);
        check("oe_in_latch_a", oe_n_a, 1);
        a_rises = 0; a_saw_lat = 1'b1; lat_cnt_a++;
      end
      if (fd_a) begin
        check("frame_period_a", cyc - ((fd_cnt_a == 0) ? rel_cyc : a_fd_ref), FRAME_A);
        a_fd_ref = cyc; fd_cnt_a++;
      end
    end
  end

  // Monitor for the 4-plane variant: two frames of shift data and timing.
  logic b_off = 1'b0, b_first = 1'b1, b_prev_pclk = 1'b0;
  int b_fd_ref = 0;

  always @(negedge clk) begin
    shift_t e;
    if (!rst_b && !b_off) begin
      if (pclk_b && !b_prev_pclk) begin
        if (b_first) begin
          check("first_rise_b", cyc - rel_cyc, 2 + CD_B);
          b_first = 1'b0;
        end
        check("shift_queue_b", q_shift_b.size() > 0, 1);
        if (q_shift_b.size() > 0) begin
          e = q_shift_b.pop_front();
          check("addr_b", bus_b.ram_address, e.addr);
          check("rgb_b", {r1_b, g1_b, b1_b, r2_b, g2_b, b2_b}, e.rgb);
        end
      end
      b_prev_pclk = pclk_b;
      if (fd_b) begin
        check("frame_period_b", cyc - ((fd_cnt_b == 0) ? rel_cyc : b_fd_ref), FRAME_B);
        b_fd_ref = cyc; fd_cnt_b++;
        if (fd_cnt_b == 2) begin
          check("queue_drained_b", q_shift_b.size(), 0);
          b_off = 1'b1;
        end
      end
    end
  end

  initial begin
    repeat (99000) @(posedge clk);
    $display("FAIL watchdog: bench still running after 99000 cycles");
    $fatal(1);
  end

  initial begin
    int k;
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int i = 0; i < 512; i++) begin
      if (i < 32)      mem_a[i] = {24'h0000FF, 24'hFF0000};
      else if (i < 64) mem_a[i] = {24'h000000, 24'h810000};
      else             mem_a[i] = {16'($urandom), $urandom};
      if (i < 32)      mem_b[i] = {24'h0F0F0F, 24'h0F0F0F};
      else if (i < 64) mem_b[i] = {24'hF0F0F0, 24'hF0F0F0};
      else             mem_b[i] = {16'($urandom), $urandom};
    end
    push_frame_a();
    push_frame_a();
    push_frame_b();
    push_frame_b();

    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", bus_a.ram_address, 0);
    check("rst_rgb", {r1_a, g1_a, b1_a, r2_a, g2_a, b2_a}, 0);
    check("rst_pclk", pclk_a, 0);
    check("rst_lat", lat_a, 0);
    check("rst_oe_n", oe_n_a, 1);
    check("rst_row_addr", row_addr_a, 0);
    check("rst_frame_done", fd_a, 0);
    check("rst_oe_n_b", oe_n_b, 1);
    rst_a = 1'b0;
    rst_b = 1'b0;
    rel_cyc = cyc;

    while (fd_cnt_b < 2 && cyc < 40000) @(posedge clk);
    check("frames_seen_b", fd_cnt_b, 2);

    while (lat_cnt_a < RESET_LAT && cyc < 90000) @(posedge clk);
    check("reached_row5_plane3", lat_cnt_a, RESET_LAT);
    check("frames_seen_a", fd_cnt_a, 1);
    repeat (20) @(posedge clk);
    #1;
    check("mid_show_oe_n", oe_n_a, 0);
    check("mid_show_row", row_addr_a, 5);
    rst_a = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_oe_n", oe_n_a, 1);
    check("mid_rst_lat", lat_a, 0);
    check("mid_rst_row_addr", row_addr_a, 0);
    check("mid_rst_addr", bus_a.ram_address, 0);
    check("mid_rst_pclk", pclk_a, 0);
    rst_a = 1'b0;
    rel_cyc = cyc;
    k = 0;
    while (!pclk_a && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("first_rise_after_rst", k, 2 + CD_A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
